decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
Parametrised, registered successor to the 4-to-16 decoder. It turns an AW-bit binary index into a 2**AW-bit output vector in one of four modes: one-hot, thermometer, ascending scan or descending scan. The scan modes walk a single hot bit across the outputs, one position per cycle, for row/column strobing. It sits between a control FSM (valid/ready producer) and select/strobe consumers.

Parameters:
AW, 4, index width; legal range 1..6.
OW, 2**AW, output width; derived, must not be overridden.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request this cycle.
mode  input  2  0=one-hot, 1=thermometer, 2=scan up, 3=scan down; sampled on accept.
A  input  AW  binary index; sampled on accept.
Z  output  OW  decoded output, registered.
z_valid  output  1  Z holds a valid pattern this cycle.
z_last  output  1  final pattern of the current request.

Behaviour:
- Accept: in_valid & in_ready at a rising edge. mode and A are captured into internal regs on accept.
- Reset (rst_n low at an edge): state=IDLE, Z=0, z_valid=0, z_last=0, counter=0, captured regs=0.
- in_ready=0 while rst_n is low, else in_ready = (state==IDLE). Combinational from state and rst_n only; does not depend on in_valid.
- FSM states: IDLE, SCAN.
- IDLE, no accept -> next cycle Z=0, z_valid=0, z_last=0.
- IDLE, accept, mode 0 -> next cycle Z has only bit A set, z_valid=1, z_last=1; stay IDLE.
- IDLE, accept, mode 1 -> next cycle Z[i]=1 for all i<=A, else 0 (A=OW-1 gives all ones); z_valid=z_last=1; stay IDLE.
- IDLE, accept, mode 2 -> next cycle Z=onehot(0), z_valid=1.
  - If A==0: z_last=1, stay IDLE.
  - Else: counter=0, enter SCAN.
- IDLE, accept, mode 3 -> next cycle Z=onehot(A), z_valid=1.
  - If A==0: z_last=1, stay IDLE.
  - Else: counter=A, enter SCAN.
- SCAN, each cycle: counter steps +1 (mode 2) or -1 (mode 3); Z=onehot(new counter); z_valid=1.
  - On the edge that presents the final position (A for mode 2, 0 for mode 3): z_last=1, state returns to IDLE.
- A scan request therefore yields exactly A+1 consecutive z_valid cycles, one per position, with z_last only on the final one.
- Latency: 1 cycle from accept to first pattern.
- Throughput:
  - One request per cycle for modes 0/1.
  - Modes 2/3 stall input for A cycles; in_ready is low from the cycle after accept up to, but not including, the z_last cycle.
- Back-to-back: in_ready is 1 during the z_last cycle of a scan, so a new accept there makes its first pattern directly follow the last scan pattern, with no bubble.
- in_valid while in_ready=0 is ignored (no capture); mode and A changing during SCAN have no effect.
- Counter is AW bits wide; it never wraps, because termination is by equality before overflow.
- Z, z_valid and z_last are direct flop outputs; no combinational path from inputs to them.
- Reset mid-scan: aborts at that edge. Outputs go to reset values the next cycle, and the scan does not resume.

Test Plan:
- Reset, then AW=4, mode 0, A=2, one-cycle in_valid -> next cycle Z=0x0004, z_valid=1, z_last=1; the cycle after, Z=0x0000, z_valid=0.
- Mode 1, A=5 -> Z=0x003F for one cycle. Mode 1, A=15 -> Z=0xFFFF.
- Mode 2, A=3 -> Z=0x0001, 0x0002, 0x0004, 0x0008 on 4 consecutive cycles; z_last only on 0x0008; in_ready=0 on cycles 1-3 after accept; in_valid pulses during that window are ignored.
- Mode 3, A=2, held in_valid with a mode-0 A=7 request queued -> Z=0x0004, 0x0002, 0x0001, then 0x0080 the very next cycle (back-to-back accept during z_last).
- Mode 2, A=0 -> single cycle Z=0x0001 with z_valid=z_last=1; in_ready never drops.
- Mode 2, A=15, rst_n low 5 cycles after accept -> next cycle Z=0, z_valid=0, in_ready=0; after release, in_ready=1 and no further scan output.

Source files
------------

// File: rtl/decoder_seq.sv
// Registered AW-to-2**AW decoder: one-hot, thermometer, scan-up and scan-down modes.
// 1-cycle latency; in_ready drops while a scan walks its positions, rises again on its z_last cycle.
module decoder_seq #(
   parameter  int AW = 4,
   localparam int OW = 2**AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] A,
   output logic [OW-1:0] Z,
   output logic          z_valid,
   output logic          z_last
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [1:0]    MODE_ONEHOT = 2'd0;
   localparam logic [1:0]    MODE_THERM  = 2'd1;
   localparam logic [1:0]    MODE_UP     = 2'd2;
   localparam logic [AW-1:0] CNT_ONE     = {{(AW-1){1'b0}}, 1'b1};

   state_t        r_state, w_state_nx;
   logic [AW-1:0] r_cnt, w_cnt_nx;
   logic [1:0]    r_mode, w_mode_nx;
   logic [AW-1:0] r_a, w_a_nx;
   logic [OW-1:0] r_z, w_z_nx;
   logic          r_zv, w_zv_nx;
   logic          r_zl, w_zl_nx;
   logic          w_acc;
   logic [AW-1:0] w_scan_end;

   function automatic logic [OW-1:0] f_onehot(input logic [AW-1:0] idx);
      logic [OW-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign in_ready   = rst_n && (r_state == IDLE);
   assign w_acc      = in_valid && in_ready;
   assign w_scan_end = (r_mode == MODE_UP) ? r_a : '0;

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_mode_nx  = r_mode;
      w_a_nx     = r_a;
      w_z_nx     = '0;
      w_zv_nx    = 1'b0;
      w_zl_nx    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               w_mode_nx = mode;
               w_a_nx    = A;
               w_zv_nx   = 1'b1;
               if (mode == MODE_ONEHOT) begin
                  w_z_nx  = f_onehot(A);
                  w_zl_nx = 1'b1;
               end else if (mode == MODE_THERM) begin
                  for (int i = 0; i < OW; i++) w_z_nx[i] = (i <= int'(A));
                  w_zl_nx = 1'b1;
               end else begin
                  // Scan up starts at position 0, scan down at A; A==0 is a one-position scan.
                  w_z_nx = (mode == MODE_UP) ? f_onehot('0) : f_onehot(A);
                  if (A == '0) begin
                     w_zl_nx = 1'b1;
                  end else begin
                     w_cnt_nx   = (mode == MODE_UP) ? '0 : A;
                     w_state_nx = SCAN;
                  end
               end
            end
         end
         SCAN: begin
            w_cnt_nx = (r_mode == MODE_UP) ? r_cnt + CNT_ONE : r_cnt - CNT_ONE;
            w_z_nx   = f_onehot(w_cnt_nx);
            w_zv_nx  = 1'b1;
            if (w_cnt_nx == w_scan_end) begin
               w_zl_nx    = 1'b1;
               w_state_nx = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mode  <= '0;
         r_a     <= '0;
         r_z     <= '0;
         r_zv    <= 1'b0;
         r_zl    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_mode  <= w_mode_nx;
         r_a     <= w_a_nx;
         r_z     <= w_z_nx;
         r_zv    <= w_zv_nx;
         r_zl    <= w_zl_nx;
      end
   end

   assign Z       = r_z;
   assign z_valid = r_zv;
   assign z_last  = r_zl;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq at AW=4: vector table for single-pattern requests plus scan sequences.
module tb_decoder_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic [3:0]  A;
   logic [15:0] Z;
   logic        z_valid;
   logic        z_last;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [1:0]  mode;
      logic [3:0]  a;
      logic [15:0] z;
   } vec_t;

   vec_t vecs [10];

   decoder_seq #(.AW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mode     (mode),
      .A        (A),
      .Z        (Z),
      .z_valid  (z_valid),
      .z_last   (z_last)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [15:0] ez, input logic ev, input logic el);
      check({name, " Z"}, 32'(Z), 32'(ez));
      check({name, " z_valid"}, 32'(z_valid), 32'(ev));
      check({name, " z_last"}, 32'(z_last), 32'(el));
   endtask

   initial begin
      logic [15:0] up_exp [4];
      logic [15:0] dn_exp [3];
      logic [15:0] long_exp [5];

      vecs[0] = '{mode: 2'd0, a: 4'd2,  z: 16'h0004};
      vecs[1] = '{mode: 2'd1, a: 4'd5,  z: 16'h003F};
      vecs[2] = '{mode: 2'd1, a: 4'd15, z: 16'hFFFF};
      vecs[3] = '{mode: 2'd0, a: 4'd0,  z: 16'h0001};
      vecs[4] = '{mode: 2'd0, a: 4'd15, z: 16'h8000};
      vecs[5] = '{mode: 2'd1, a: 4'd0,  z: 16'h0001};
      vecs[6] = '{mode: 2'd2, a: 4'd0,  z: 16'h0001};
      vecs[7] = '{mode: 2'd3, a: 4'd0,  z: 16'h0001};
      vecs[8] = '{mode: 2'd1, a: 4'd7,  z: 16'h00FF};
      vecs[9] = '{mode: 2'd0, a: 4'd11, z: 16'h0800};
      up_exp   = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
      dn_exp   = '{16'h0004, 16'h0002, 16'h0001};
      long_exp = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};

      // Reset
      rst_n = 1'b0; in_valid = 1'b1; mode = 2'd0; A = 4'd3;
      tick(); tick();
      check_out("reset", 16'h0000, 1'b0, 1'b0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("post-reset in_ready", 32'(in_ready), 32'd1);

      // Single-pattern requests from the table, each followed by an idle cycle
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; mode = vecs[i].mode; A = vecs[i].a;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].z, 1'b1, 1'b1);
         in_valid = 1'b0;
         tick();
         check_out($sformatf("vec%0d idle", i), 16'h0000, 1'b0, 1'b0);
      end

      // Back-to-back one-hot requests at full rate
      in_valid = 1'b1; mode = 2'd0; A = 4'd1;
      tick();
      check_out("b2b first", 16'h0002, 1'b1, 1'b1);
      mode = 2'd1; A = 4'd3;
      tick();
      check_out("b2b second", 16'h000F, 1'b1, 1'b1);
      in_valid = 1'b0;
      tick();

      // Scan up A=3 with ignored in_valid pulses while busy
      in_valid = 1'b1; mode = 2'd2; A = 4'd3;
      tick();
      for (int k = 0; k < 4; k++) begin
         check_out($sformatf("up3 step%0d", k), up_exp[k], 1'b1, k == 3);
         check($sformatf("up3 step%0d in_ready", k), 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
         if (k < 3) begin
            in_valid = 1'b1; mode = 2'd0; A = 4'd9;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      check_out("up3 done", 16'h0000, 1'b0, 1'b0);

      // Scan down A=2 with a queued one-hot A=7 accepted on the z_last cycle
      in_valid = 1'b1; mode = 2'd3; A = 4'd2;
      tick();
      mode = 2'd0; A = 4'd7;
      for (int k = 0; k < 3; k++) begin
         check_out($sformatf("dn2 step%0d", k), dn_exp[k], 1'b1, k == 2);
         tick();
      end
      check_out("dn2 follow-on", 16'h0080, 1'b1, 1'b1);
      in_valid = 1'b0;
      tick();
      check_out("dn2 idle", 16'h0000, 1'b0, 1'b0);

      // Scan up A=15 aborted by reset five cycles after accept
      in_valid = 1'b1; mode = 2'd2; A = 4'd15;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check_out($sformatf("up15 step%0d", k), long_exp[k], 1'b1, 1'b0);
         if (k < 4) tick();
      end
      rst_n = 1'b0;
      tick();
      check_out("abort", 16'h0000, 1'b0, 1'b0);
      check("abort in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check("abort release in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 16; k++) begin
         tick();
         check($sformatf("abort quiet%0d", k), 32'({z_valid, Z}), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
